// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
//
// Purpose : constants and types shared by the UART receive path.
// Contents: BITWIDTH       - default data bits per frame
//           OVERSAMPLE_DEF - default baud ticks per serial bit
//           rx_state_e     - receive framer state encoding
package uart_pkg;

    localparam int BITWIDTH       = 8;
    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - programmable baud tick generator
//
// Purpose : free-running counter 0..BAUD_VAL producing a one-cycle TICK on
//           every wrap, i.e. one tick every BAUD_VAL+1 PCLK cycles.
// Ports   : PCLK     in  clock, rising edge
//           PRESET   in  synchronous active-high reset
//           BAUD_VAL in  8-bit divider
//           TICK     out one-cycle pulse on wrap
module uart_baud_tick (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic [7:0] BAUD_VAL,
    output logic       TICK
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [7:0] limit_q;
    logic [7:0] limit_d;
    logic       wrap;

    // The divider is captured only at a wrap, so a BAUD_VAL change never
    // shortens or stretches the period already in progress.
    assign wrap = (cnt_q == limit_q);
    assign TICK = wrap;

    always_comb begin
        cnt_d   = cnt_q + 8'd1;
        limit_d = limit_q;
        if (wrap) begin
            cnt_d   = 8'd0;
            limit_d = BAUD_VAL;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_q   <= 8'd0;
            limit_q <= BAUD_VAL;
        end else begin
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - oversampling UART receiver with held-byte interface
//
// Purpose : synchronizes RX, detects a start edge, samples each bit at
//           mid-bit using an oversampled baud tick, checks optional parity
//           and the stop bit, and holds the received byte until RD_ACK.
// Ports   : PCLK        in  clock, rising edge
//           PRESET      in  synchronous active-high reset
//           BAUD_VAL    in  tick divider (tick every BAUD_VAL+1 cycles)
//           PARITY_EN   in  parity bit present (captured at frame start)
//           PARITY_ODD  in  odd parity select (captured at frame start)
//           RX          in  asynchronous serial line, idle high
//           RD_ACK      in  one-cycle consume pulse for the held byte
//           DATAOUT     out held byte
//           RXRDY       out held byte not yet consumed
//           PARITY_ERR  out parity mismatch on the held byte
//           FRAMING_ERR out stop bit was 0 on the held byte
//           OVERFLOW    out sticky, a frame arrived while RXRDY=1
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = BITWIDTH,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [7:0]            BAUD_VAL,
    input  logic                  PARITY_EN,
    input  logic                  PARITY_ODD,
    input  logic                  RX,
    input  logic                  RD_ACK,
    output logic [DATA_WIDTH-1:0] DATAOUT,
    output logic                  RXRDY,
    output logic                  PARITY_ERR,
    output logic                  FRAMING_ERR,
    output logic                  OVERFLOW
);

    localparam int        BCW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [3:0] MID_CNT = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] BIT_END = 4'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

    logic tick;

    uart_baud_tick u_baud_tick (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .BAUD_VAL (BAUD_VAL),
        .TICK     (tick)
    );

    // ------------------------------------------------------------------
    // RX synchronizer and falling-edge detector. All flops idle at 1 so a
    // line that is already low after reset is not mistaken for an edge
    // until it has actually been seen high.
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;
    logic rx_fall;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_s_q;

    // ------------------------------------------------------------------
    // Framing state machine
    // ------------------------------------------------------------------
    rx_state_e             state_q, state_d;
    logic [3:0]            samp_q, samp_d;
    logic [BCW-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_odd_q, par_odd_d;
    logic                  par_bit_q, par_bit_d;
    logic                  frame_done;

    always_comb begin
        state_d    = state_q;
        samp_d     = samp_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        par_bit_d  = par_bit_q;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                samp_d = 4'd0;
                bit_d  = '0;
                if (rx_fall) begin
                    state_d   = ST_START;
                    par_en_d  = PARITY_EN;
                    par_odd_d = PARITY_ODD;
                end
            end

            ST_START: begin
                if (tick) begin
                    if (samp_q == MID_CNT) begin
                        // Line back high at mid-start means it was a glitch.
                        samp_d  = 4'd0;
                        bit_d   = '0;
                        state_d = rx_s_q ? ST_IDLE : ST_DATA;
                    end else begin
                        samp_d = samp_q + 4'd1;
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (samp_q == BIT_END) begin
                        samp_d  = 4'd0;
                        shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        samp_d = samp_q + 4'd1;
                    end
                end
            end

            ST_PARITY: begin
                if (tick) begin
                    if (samp_q == BIT_END) begin
                        samp_d    = 4'd0;
                        par_bit_d = rx_s_q;
                        state_d   = ST_STOP;
                    end else begin
                        samp_d = samp_q + 4'd1;
                    end
                end
            end

            ST_STOP: begin
                if (tick) begin
                    if (samp_q == BIT_END) begin
                        samp_d     = 4'd0;
                        frame_done = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        samp_d = samp_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                samp_d  = 4'd0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            samp_q    <= 4'd0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            par_bit_q <= par_bit_d;
        end
    end

    // ------------------------------------------------------------------
    // Held-byte register and status flags
    // ------------------------------------------------------------------
    logic new_perr;
    logic new_ferr;

    // Odd parity expects data^bit == 1, even expects 0.
    assign new_perr = par_en_q & (((^shift_q) ^ par_bit_q) != par_odd_q);
    // Valid only in the frame_done cycle, when rx_s is the stop sample.
    assign new_ferr = ~rx_s_q;

    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  rdy_q, rdy_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  ovf_q, ovf_d;
    logic                  ack;

    // An acknowledge only means something while a byte is held.
    assign ack = RD_ACK & rdy_q;

    always_comb begin
        dout_d = dout_q;
        rdy_d  = rdy_q;
        perr_d = perr_q;
        ferr_d = ferr_q;
        ovf_d  = ovf_q;

        if (frame_done) begin
            if (!rdy_q || ack) begin
                dout_d = shift_q;
                perr_d = new_perr;
                ferr_d = new_ferr;
                rdy_d  = 1'b1;
                if (ack) begin
                    ovf_d = 1'b0;
                end
            end else begin
                // Consumer is behind: keep the old byte, flag the loss.
                ovf_d = 1'b1;
            end
        end else if (ack) begin
            rdy_d  = 1'b0;
            perr_d = 1'b0;
            ferr_d = 1'b0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            dout_q <= '0;
            rdy_q  <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            rdy_q  <= rdy_d;
            perr_q <= perr_d;
            ferr_q <= ferr_d;
            ovf_q  <= ovf_d;
        end
    end

    assign DATAOUT     = dout_q;
    assign RXRDY       = rdy_q;
    assign PARITY_ERR  = perr_q;
    assign FRAMING_ERR = ferr_q;
    assign OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb/tb_uart_rx_framer.sv - directed self-checking bench for uart_rx_framer
module tb_uart_rx_framer;

    localparam int BIT_CYC = 64;  // BAUD_VAL=3 -> 4 cycles/tick, 16 ticks/bit

    logic       clk = 1'b0;
    logic       PRESET;
    logic [7:0] BAUD_VAL;
    logic       PARITY_EN;
    logic       PARITY_ODD;
    logic       RX;
    logic       RD_ACK;
    logic [7:0] DATAOUT;
    logic       RXRDY;
    logic       PARITY_ERR;
    logic       FRAMING_ERR;
    logic       OVERFLOW;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_rx_framer dut (
        .PCLK        (clk),
        .PRESET      (PRESET),
        .BAUD_VAL    (BAUD_VAL),
        .PARITY_EN   (PARITY_EN),
        .PARITY_ODD  (PARITY_ODD),
        .RX          (RX),
        .RD_ACK      (RD_ACK),
        .DATAOUT     (DATAOUT),
        .RXRDY       (RXRDY),
        .PARITY_ERR  (PARITY_ERR),
        .FRAMING_ERR (FRAMING_ERR),
        .OVERFLOW    (OVERFLOW)
    );

    // Serial frame driver; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input bit with_par,
                              input logic pbit, input logic stop);
        RX = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        if (with_par) begin
            RX = pbit;
            repeat (BIT_CYC) @(negedge clk);
        end
        RX = stop;
        repeat (BIT_CYC) @(negedge clk);
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_ack();
        RD_ACK = 1'b1;
        @(negedge clk);
        RD_ACK = 1'b0;
        @(negedge clk);
    endtask

    // Bounded wait for the completion strobe; used only to time stimulus.
    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (dut.frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        PRESET = 1'b1; RX = 1'b1; BAUD_VAL = 8'd3;
        PARITY_EN = 1'b0; PARITY_ODD = 1'b0; RD_ACK = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (DATAOUT !== 8'h00) begin n_fail++; $display("FAIL reset_dataout got %h exp 00", DATAOUT); end
        n_checks++; if (RXRDY !== 1'b0) begin n_fail++; $display("FAIL reset_rxrdy got %b exp 0", RXRDY); end
        n_checks++; if (PARITY_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %b exp 0", PARITY_ERR); end
        n_checks++; if (FRAMING_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b exp 0", FRAMING_ERR); end
        n_checks++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", OVERFLOW); end
        PRESET = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        fork
            send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
            begin
                wait_done(ok);
                n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_done_timeout got %b exp 1", ok); end
                n_checks++; if (RXRDY !== 1'b0) begin n_fail++; $display("FAIL basic_latency_pre got %b exp 0", RXRDY); end
                @(negedge clk);
                n_checks++; if (RXRDY !== 1'b1) begin n_fail++; $display("FAIL basic_latency_post got %b exp 1", RXRDY); end
            end
        join
        n_checks++; if (DATAOUT !== 8'h5A) begin n_fail++; $display("FAIL basic_data got %h exp 5a", DATAOUT); end
        n_checks++; if ({PARITY_ERR, FRAMING_ERR, OVERFLOW} !== 3'b000) begin n_fail++; $display("FAIL basic_flags got %b exp 000", {PARITY_ERR, FRAMING_ERR, OVERFLOW}); end
        pulse_ack();
        n_checks++; if (RXRDY !== 1'b0) begin n_fail++; $display("FAIL basic_ack_rxrdy got %b exp 0", RXRDY); end
        n_checks++; if (DATAOUT !== 8'h5A) begin n_fail++; $display("FAIL basic_ack_hold got %h exp 5a", DATAOUT); end
        pulse_ack();
        n_checks++; if ({RXRDY, DATAOUT} !== {1'b0, 8'h5A}) begin n_fail++; $display("FAIL idle_ack_noeffect got %b/%h exp 0/5a", RXRDY, DATAOUT); end
    endtask

    task automatic test_parity();
        PARITY_EN = 1'b1; PARITY_ODD = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        n_checks++; if (PARITY_ERR !== 1'b1) begin n_fail++; $display("FAIL par_even_bad got %b exp 1", PARITY_ERR); end
        n_checks++; if (DATAOUT !== 8'hA5) begin n_fail++; $display("FAIL par_even_bad_data got %h exp a5", DATAOUT); end
        pulse_ack();
        n_checks++; if (PARITY_ERR !== 1'b0) begin n_fail++; $display("FAIL par_ack_clear got %b exp 0", PARITY_ERR); end
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        n_checks++; if ({RXRDY, PARITY_ERR} !== 2'b10) begin n_fail++; $display("FAIL par_even_good got %b exp 10", {RXRDY, PARITY_ERR}); end
        pulse_ack();
        // Odd parity; PARITY_ODD is flipped mid-frame and must not matter.
        PARITY_ODD = 1'b1;
        fork
            send_frame(8'h07, 1'b1, 1'b0, 1'b1);
            begin repeat (3 * BIT_CYC) @(negedge clk); PARITY_ODD = 1'b0; end
        join
        n_checks++; if ({RXRDY, PARITY_ERR, DATAOUT} !== {2'b10, 8'h07}) begin n_fail++; $display("FAIL par_odd_good got %b%b/%h exp 10/07", RXRDY, PARITY_ERR, DATAOUT); end
        pulse_ack();
        PARITY_EN = 1'b0; PARITY_ODD = 1'b0;
    endtask

    task automatic test_glitch();
        RX = 1'b0;
        repeat (12) @(negedge clk);
        RX = 1'b1;
        repeat (4 * BIT_CYC) @(negedge clk);
        n_checks++; if (RXRDY !== 1'b0) begin n_fail++; $display("FAIL glitch_rxrdy got %b exp 0", RXRDY); end
        n_checks++; if (dut.state_q !== uart_pkg::ST_IDLE) begin n_fail++; $display("FAIL glitch_idle got %0d exp 0", dut.state_q); end
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({RXRDY, FRAMING_ERR, DATAOUT} !== {2'b11, 8'h3C}) begin n_fail++; $display("FAIL framing_err got %b%b/%h exp 11/3c", RXRDY, FRAMING_ERR, DATAOUT); end
        pulse_ack();
        repeat (20 * BIT_CYC) @(negedge clk);
        n_checks++; if (RXRDY !== 1'b0) begin n_fail++; $display("FAIL low_line_no_frame got %b exp 0", RXRDY); end
        RX = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
        send_frame(8'h96, 1'b0, 1'b0, 1'b1);
        n_checks++; if ({RXRDY, FRAMING_ERR, DATAOUT} !== {2'b10, 8'h96}) begin n_fail++; $display("FAIL framing_recover got %b%b/%h exp 10/96", RXRDY, FRAMING_ERR, DATAOUT); end
        pulse_ack();
    endtask

    task automatic test_overflow();
        bit ok;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        n_checks++; if ({RXRDY, OVERFLOW, DATAOUT} !== {2'b11, 8'h11}) begin n_fail++; $display("FAIL ovf_set got %b%b/%h exp 11/11", RXRDY, OVERFLOW, DATAOUT); end
        pulse_ack();
        n_checks++; if ({RXRDY, OVERFLOW} !== 2'b00) begin n_fail++; $display("FAIL ovf_ack_clear got %b exp 00", {RXRDY, OVERFLOW}); end
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        fork
            send_frame(8'h22, 1'b0, 1'b0, 1'b1);
            begin
                wait_done(ok);
                n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ovf_done_timeout got %b exp 1", ok); end
                RD_ACK = 1'b1;
                @(negedge clk);
                RD_ACK = 1'b0;
            end
        join
        n_checks++; if ({RXRDY, OVERFLOW, DATAOUT} !== {2'b10, 8'h22}) begin n_fail++; $display("FAIL ack_on_done got %b%b/%h exp 10/22", RXRDY, OVERFLOW, DATAOUT); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d = 8'h55;
        RX = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            RX = d[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        RX = d[3];
        repeat (BIT_CYC / 2) @(negedge clk);
        PRESET = 1'b1; RX = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if ({RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW, DATAOUT} !== 12'h000) begin n_fail++; $display("FAIL midreset_outputs got %b%b%b%b/%h exp 0000/00", RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW, DATAOUT); end
        // Start bit begins in the very first cycle after release.
        PRESET = 1'b0;
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        n_checks++; if ({RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW, DATAOUT} !== {4'b1000, 8'h81}) begin n_fail++; $display("FAIL post_reset_frame got %b%b%b%b/%h exp 1000/81", RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW, DATAOUT); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_framing();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the number of data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, the number of baud ticks per bit.
REQ-003 SHALL have port PCLK  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port PRESET  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port BAUD_VAL  input  8  baud divider; tick period is BAUD_VAL+1 PCLK cycles.
REQ-006 SHALL have port PARITY_EN  input  1  1 means a parity bit follows the data bits.
REQ-007 SHALL have port PARITY_ODD  input  1  1 selects odd parity, 0 selects even parity.
REQ-008 SHALL have port RX  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port RD_ACK  input  1  one-cycle pulse from the consumer; consumes the held byte.
REQ-010 SHALL have port DATAOUT  output  DATA_WIDTH  the held received byte.
REQ-011 SHALL have port RXRDY  output  1  1 while DATAOUT holds an unconsumed byte.
REQ-012 SHALL have port PARITY_ERR  output  1  parity mismatch on the held byte.
REQ-013 SHALL have port FRAMING_ERR  output  1  stop bit sampled 0 on the held byte.
REQ-014 SHALL have port OVERFLOW  output  1  sticky; a frame completed while RXRDY=1.

Function
REQ-015 SHALL pass RX through a 2-flop synchronizer, both flops preset to 1; all framing uses the synchronized value rx_s.
REQ-016 SHALL run an 8-bit tick counter from 0 to BAUD_VAL, asserting a 1-cycle tick on wrap; with BAUD_VAL=0 a tick occurs every cycle; a BAUD_VAL change takes effect at the next wrap.
REQ-017 SHALL implement the state machine states IDLE, START, DATA, PARITY, STOP, each counting ticks in a 4-bit sample counter.
REQ-018 IDLE -> START SHALL occur on a falling edge of rx_s (previous 1, current 0); the sample counter clears on entry; a level-low line without an edge never starts a frame.
REQ-019 START SHALL sample rx_s at sample count OVERSAMPLE/2-1 (7); on 0 go to DATA with counters cleared, on 1 return to IDLE (glitch rejection, no flags change).
REQ-020 DATA SHALL sample every OVERSAMPLE ticks at mid-bit, shift LSB first, and after DATA_WIDTH bits go to PARITY if PARITY_EN=1, else to STOP.
REQ-021 PARITY SHALL sample one bit; the error is (XOR of data ^ sampled bit) != PARITY_ODD.
REQ-022 STOP SHALL sample one bit at mid-bit; a 0 sets the frame's framing error; the machine then returns to IDLE on the same cycle the byte completes.
REQ-023 On completion with RXRDY=0, or RXRDY=1 with RD_ACK=1 on the same cycle, the block SHALL, on the next edge, load DATAOUT and the PARITY_ERR and FRAMING_ERR of the new frame, and set RXRDY=1.
REQ-024 On completion with RXRDY=1 and RD_ACK=0, the block SHALL discard the new frame, keep DATAOUT and the error flags, and set OVERFLOW=1.
REQ-025 RD_ACK with no completion on the same cycle SHALL clear RXRDY, PARITY_ERR, FRAMING_ERR and OVERFLOW on the next edge; DATAOUT holds its value.
REQ-026 RD_ACK while RXRDY=0 SHALL have no effect.
REQ-027 Latency: RXRDY SHALL rise exactly one PCLK after the tick at which the stop bit is sampled.
REQ-028 PARITY_EN and PARITY_ODD SHALL be sampled at frame start and held for the whole frame.

Reset
REQ-029 PRESET=1 SHALL force state IDLE, counters to 0, synchronizer flops to 1, DATAOUT=0, and RXRDY=PARITY_ERR=FRAMING_ERR=OVERFLOW=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no flag or data update.
REQ-031 A frame whose start edge falls in the first cycle after reset release SHALL be received normally.

Structure
REQ-032 The state encoding, the OVERSAMPLE default and the BITWIDTH constant (8) SHALL live in the shared uart package.
REQ-033 The tick counter SHALL be a sub-module uart_baud_tick (ports PCLK, PRESET, BAUD_VAL, TICK).

Verification
REQ-034 BAUD_VAL=3, no parity, frame 0x5A sent at 64 PCLK/bit -> DATAOUT=0x5A, RXRDY=1, no error flags.
REQ-035 PARITY_EN=1, PARITY_ODD=0, 0xA5 sent with parity bit 1 (bad) -> PARITY_ERR=1, DATAOUT=0xA5.
REQ-036 Stop bit driven 0 on 0x3C -> FRAMING_ERR=1; a line held low afterwards gives no new frame until a 1->0 edge.
REQ-037 RX low pulse of 3 ticks (shorter than the mid-start sample) -> return to IDLE, RXRDY stays 0.
REQ-038 Send 0x11 then 0x22 without RD_ACK -> DATAOUT=0x11, OVERFLOW=1; RD_ACK on the 0x22 completion cycle instead -> DATAOUT=0x22, OVERFLOW=0.
REQ-039 PRESET pulsed during the 4th data bit -> outputs at their reset values; the next 0x81 frame is received correctly.
